// File: rtl/button_conditioner.sv
// Input conditioning for the pad buttons: two-flop synchroniser, per-button
// debounce, and sticky hold of short presses until the next frame snapshot.
module button_conditioner #(
  parameter int BUTTON_COUNT    = 12,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_WIDTH       = 18,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BUTTON_COUNT-1:0] buttons_raw,
  input  logic                    snapshot,
  output logic [BUTTON_COUNT-1:0] buttons_out,
  output logic [BUTTON_COUNT-1:0] stable,
  output logic [BUTTON_COUNT-1:0] press_event
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [BUTTON_COUNT-1:0] r;
  logic [BUTTON_COUNT-1:0] sync1;
  logic [BUTTON_COUNT-1:0] s;
  logic [BUTTON_COUNT-1:0] sticky;
  logic [BUTTON_COUNT-1:0] flip;
  logic [BUTTON_COUNT-1:0] rise;
  logic [CNT_WIDTH-1:0]    cnt [BUTTON_COUNT];

  // Normalise pad polarity so everything downstream treats 1 as pressed.
  assign r = (ACTIVE_LOW != 0) ? ~buttons_raw : buttons_raw;

  always_comb begin
    flip = '0;
    for (int unsigned i = 0; i < BUTTON_COUNT; i++) begin
      flip[i] = (s[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise = flip & s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      s           <= '0;
      stable      <= '0;
      sticky      <= '0;
      press_event <= '0;
      for (int unsigned i = 0; i < BUTTON_COUNT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1       <= r;
      s           <= sync1;
      stable      <= stable ^ flip;
      press_event <= rise;
      // A rise landing on the snapshot cycle must survive into the next frame.
      sticky      <= (snapshot ? '0 : sticky) | rise;
      for (int unsigned i = 0; i < BUTTON_COUNT; i++) begin
        if (s[i] == stable[i] || flip[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign buttons_out = stable | sticky;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: three instances (active-high D=4, active-low
// D=4, active-high D=1) checked every cycle against a sample-window model.
module tb_button_conditioner;

  localparam int DB [3] = '{4, 4, 1};
  localparam int AL [3] = '{0, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] raw_v  [3];
  logic        rst_v  [3];
  logic        snap_v [3];
  logic [11:0] bo_v   [3];
  logic [11:0] st_v   [3];
  logic [11:0] pe_v   [3];

  button_conditioner #(.BUTTON_COUNT(12), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .reset(rst_v[0]), .buttons_raw(raw_v[0]), .snapshot(snap_v[0]),
    .buttons_out(bo_v[0]), .stable(st_v[0]), .press_event(pe_v[0]));

  button_conditioner #(.BUTTON_COUNT(12), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset(rst_v[1]), .buttons_raw(raw_v[1]), .snapshot(snap_v[1]),
    .buttons_out(bo_v[1]), .stable(st_v[1]), .press_event(pe_v[1]));

  button_conditioner #(.BUTTON_COUNT(12), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(1), .ACTIVE_LOW(0)) dut_c (
    .clk(clk), .reset(rst_v[2]), .buttons_raw(raw_v[2]), .snapshot(snap_v[2]),
    .buttons_out(bo_v[2]), .stable(st_v[2]), .press_event(pe_v[2]));

  int n_checks = 0;
  int n_pass   = 0;
  int pe3_cnt  = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: hist[k][j] is the normalised raw sample taken j+1 edges ago.
  // The synchronised level seen at an edge is the sample from two edges back,
  // and a bit flips once the last D synchronised samples all differ from it.
  logic [11:0] m_hist [3][8];
  logic [11:0] m_st [3];
  logic [11:0] m_sk [3];
  logic [11:0] m_pe [3];

  always @(posedge clk) begin
    logic [11:0] r, s, flip;
    for (int k = 0; k < 3; k++) begin
      r = (AL[k] != 0) ? ~raw_v[k] : raw_v[k];
      if (rst_v[k]) begin
        m_st[k] = '0;
        m_sk[k] = '0;
        m_pe[k] = '0;
        for (int j = 0; j < 8; j++) m_hist[k][j] = '0;
      end else begin
        s    = m_hist[k][1];
        flip = '1;
        for (int j = 1; j <= DB[k]; j++) flip &= m_hist[k][j] ^ m_st[k];
        m_pe[k] = flip & s;
        m_st[k] = m_st[k] ^ flip;
        m_sk[k] = (snap_v[k] ? 12'h000 : m_sk[k]) | m_pe[k];
        for (int j = 7; j >= 1; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = r;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("stable[%0d]", k), st_v[k], m_st[k]);
        chk($sformatf("press_event[%0d]", k), pe_v[k], m_pe[k]);
        chk($sformatf("buttons_out[%0d]", k), bo_v[k], m_st[k] | m_sk[k]);
      end
      if (pe_v[0][3]) pe3_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_v[k]  = 1'b1;
      snap_v[k] = 1'b0;
    end
    raw_v[0] = 12'h000;
    raw_v[1] = 12'hFFF;
    raw_v[2] = 12'h000;
    tick(2);
    for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;
    chk("reset_stable_a", st_v[0], 12'h000);
    chk("reset_out_a", bo_v[0], 12'h000);
    chk("reset_pe_a", pe_v[0], 12'h000);
    chk_en = 1'b1;

    // Bit 11 press: accepted on the sixth edge after the change.
    raw_v[0] = 12'h800;
    tick(5);
    chk("t1_pre_stable", st_v[0], 12'h000);
    tick(1);
    chk("t1_stable", st_v[0], 12'h800);
    chk("t1_pe", pe_v[0], 12'h800);
    chk("t1_model", m_st[0], 12'h800);
    tick(1);
    chk("t1_pe_off", pe_v[0], 12'h000);
    chk("t1_out", bo_v[0], 12'h800);

    // Bit 3 glitch: high 3, low 1, high again restarts the count.
    raw_v[0] = 12'h808;
    tick(3);
    raw_v[0] = 12'h800;
    tick(1);
    raw_v[0] = 12'h808;
    tick(5);
    chk("t2_pre_stable", st_v[0], 12'h800);
    tick(1);
    chk("t2_stable", st_v[0], 12'h808);
    chk("t2_pe", pe_v[0], 12'h008);
    snap_v[0] = 1'b1;
    tick(1);
    snap_v[0] = 1'b0;

    // Bit 5 short press held by sticky until the snapshot.
    raw_v[0] = 12'h828;
    tick(6);
    chk("t3_stable", st_v[0], 12'h828);
    raw_v[0] = 12'h808;
    tick(6);
    chk("t3_released", st_v[0], 12'h808);
    chk("t3_sticky_out", bo_v[0], 12'h828);
    snap_v[0] = 1'b1;
    tick(1);
    snap_v[0] = 1'b0;
    chk("t3_cleared", bo_v[0], 12'h808);

    // Bit 1 rise coincident with snapshot survives into the next frame.
    raw_v[0] = 12'h80A;
    tick(5);
    snap_v[0] = 1'b1;
    tick(1);
    snap_v[0] = 1'b0;
    chk("t4_stable", st_v[0], 12'h80A);
    raw_v[0] = 12'h808;
    tick(6);
    chk("t4_released", st_v[0], 12'h808);
    chk("t4_sticky_out", bo_v[0], 12'h80A);
    snap_v[0] = 1'b1;
    tick(2);
    snap_v[0] = 1'b0;
    chk("t4_cleared", bo_v[0], 12'h808);

    // Active-low instance: idle all-ones reads as nothing pressed.
    chk("t5_idle", st_v[1], 12'h000);
    raw_v[1] = 12'hFFE;
    tick(5);
    chk("t5_pre", st_v[1], 12'h000);
    tick(1);
    chk("t5_stable", st_v[1], 12'h001);
    chk("t5_pe", pe_v[1], 12'h001);
    raw_v[1] = 12'hFFC;
    tick(3);
    rst_v[1] = 1'b1;
    tick(1);
    rst_v[1] = 1'b0;
    chk("t5_rst_stable", st_v[1], 12'h000);
    chk("t5_rst_out", bo_v[1], 12'h000);
    chk("t5_rst_pe", pe_v[1], 12'h000);
    tick(5);
    chk("t5_reaccept_pre", st_v[1], 12'h000);
    tick(1);
    chk("t5_reaccept", st_v[1], 12'h003);
    chk("t5_reaccept_pe", pe_v[1], 12'h003);

    // DEBOUNCE_CYCLES=1: accepted on the third edge.
    raw_v[2] = 12'hA28;
    tick(2);
    chk("t6_pre", st_v[2], 12'h000);
    tick(1);
    chk("t6_stable", st_v[2], 12'hA28);
    chk("t6_pe", pe_v[2], 12'hA28);
    tick(1);
    chk("t6_pe_off", pe_v[2], 12'h000);
    chk("t6_out", bo_v[2], 12'hA28);

    tick(3);
    chk("t2_one_pe_bit3", 12'(pe3_cnt), 12'h001);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
